// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, the inverse S-box and GF(2^8) helpers.
package aes_pkg;

    localparam int Nb      = 4;
    localparam int BLOCK_W = 128;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_state_t;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[8*(255 - int'(b)) +: 8];
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply; constant operands fold to XOR trees.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_cipher_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey and, unless last is set, InvMixColumns.
module inv_cipher_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] rkey,
    input  logic               last,
    output logic [BLOCK_W-1:0] state_out
);

    logic [7:0] sb [16];
    logic [7:0] ak [16];

    // Byte k sits at bits [127-8k -: 8] and is state[k%4][k/4].
    always_comb begin : p_round
        logic [31:0] mixed;
        mixed     = '0;
        state_out = '0;
        // Row r of the result column c comes from input column (c - r) mod 4.
        for (int c = 0; c < Nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb[r + 4*c] = inv_sbox(state_in[BLOCK_W-1 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            ak[i] = sb[i] ^ rkey[BLOCK_W-1 - 8*i -: 8];
        end
        for (int c = 0; c < Nb; c++) begin
            mixed = {
                gmul(8'h0e, ak[4*c]) ^ gmul(8'h0b, ak[4*c+1]) ^ gmul(8'h0d, ak[4*c+2]) ^ gmul(8'h09, ak[4*c+3]),
                gmul(8'h09, ak[4*c]) ^ gmul(8'h0e, ak[4*c+1]) ^ gmul(8'h0b, ak[4*c+2]) ^ gmul(8'h0d, ak[4*c+3]),
                gmul(8'h0d, ak[4*c]) ^ gmul(8'h09, ak[4*c+1]) ^ gmul(8'h0e, ak[4*c+2]) ^ gmul(8'h0b, ak[4*c+3]),
                gmul(8'h0b, ak[4*c]) ^ gmul(8'h0d, ak[4*c+1]) ^ gmul(8'h09, ak[4*c+2]) ^ gmul(8'h0e, ak[4*c+3])
            };
            state_out[BLOCK_W-1 - 32*c -: 32] = last ? {ak[4*c], ak[4*c+1], ak[4*c+2], ak[4*c+3]} : mixed;
        end
    end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, Nr clocks per block.
//
// Handshake: start is a single-cycle-sampled request, not a held valid.
// It is taken on a rising edge where the engine is idle or is executing its
// final round (so a held start streams one block every Nr cycles); at any
// other edge it is dropped, never queued. done pulses for one cycle when
// out_block is updated; out_block then holds until the next done.
module inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [BLOCK_W-1:0]         in_block,
    input  logic [BLOCK_W*(Nr+1)-1:0]  w,
    output logic                       busy,
    output logic                       done,
    output logic [BLOCK_W-1:0]         out_block,
    output fsm_state_t                 dbg_state
);

    localparam int           KW        = BLOCK_W * (Nr + 1);
    localparam logic [3:0]   RND_FIRST = 4'(Nr - 1);
    // A mismatched Nr/Nk pair has no valid key schedule, so it never starts.
    localparam bit           CFG_OK    = (Nr == Nk + 6);

    fsm_state_t          fsm_q, fsm_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [BLOCK_W-1:0]  state_q, state_d;
    logic                busy_d, done_d;
    logic [BLOCK_W-1:0]  out_d;
    logic [BLOCK_W-1:0]  rkey;
    logic [BLOCK_W-1:0]  round_out;
    logic                last;
    logic                accept;

    assign last      = (rnd_q == 4'd0);
    assign dbg_state = fsm_q;

    // Round-key select: key r lives at w[KW-1-128r -: 128].
    always_comb begin
        rkey = '0;
        for (int r = 0; r <= Nr; r++) begin
            if (rnd_q == 4'(r)) rkey = w[KW-1 - BLOCK_W*r -: BLOCK_W];
        end
    end

    inv_cipher_round u_round (
        .state_in  (state_q),
        .rkey      (rkey),
        .last      (last),
        .state_out (round_out)
    );

    // Next-state logic: load on accept, one round per cycle, finish at rnd 0.
    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        busy_d  = busy;
        done_d  = 1'b0;
        out_d   = out_block;
        accept  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                accept = start && CFG_OK;
            end
            S_RUN: begin
                state_d = round_out;
                if (last) begin
                    out_d  = round_out;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = S_IDLE;
                    accept = start && CFG_OK;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
        if (accept) begin
            state_d = in_block ^ w[KW-1 - BLOCK_W*Nr -: BLOCK_W];
            rnd_d   = RND_FIRST;
            busy_d  = 1'b1;
            fsm_d   = S_RUN;
        end
    end

    // State, counter and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= S_IDLE;
            rnd_q     <= 4'd0;
            state_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_block <= '0;
        end else begin
            fsm_q     <= fsm_d;
            rnd_q     <= rnd_d;
            state_q   <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            out_block <= out_d;
        end
    end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter at Nr=10/12/14. The reference builds its own
// S-box from GF(2^8) inversion, expands keys, and encrypts forward so that
// decryption results can be predicted for random blocks.
module tb_inv_cipher_iter;
    import aes_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [2:0]         start_v;
    logic [2:0]         busy_v;
    logic [2:0]         done_v;
    logic [127:0]       in_v  [3];
    logic [127:0]       out_v [3];
    fsm_state_t         dbg_v [3];
    logic [1407:0]      w10;
    logic [1663:0]      w12;
    logic [1919:0]      w14;

    logic [7:0]         sbox_t [256];
    logic [127:0]       exp_q [$];
    int                 n_chk;
    int                 n_err;

    inv_cipher_iter #(.Nr(10), .Nk(4)) u10 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_block(in_v[0]), .w(w10),
        .busy(busy_v[0]), .done(done_v[0]), .out_block(out_v[0]), .dbg_state(dbg_v[0])
    );
    inv_cipher_iter #(.Nr(12), .Nk(6)) u12 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_block(in_v[1]), .w(w12),
        .busy(busy_v[1]), .done(done_v[1]), .out_block(out_v[1]), .dbg_state(dbg_v[1])
    );
    inv_cipher_iter #(.Nr(14), .Nk(8)) u14 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_block(in_v[2]), .w(w14),
        .busy(busy_v[2]), .done(done_v[2]), .out_block(out_v[2]), .dbg_state(dbg_v[2])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    // Key schedule, word i at bits [1919-32i -: 32]; key is left-aligned.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   wd [60];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1919:0] res;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                wd[i] = key[255 - 32*i -: 32];
            end else begin
                tmp = wd[i-1];
                if (i % nk == 0) begin
                    tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                    rc  = gm(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = subw(tmp);
                end
                wd[i] = wd[i-nk] ^ tmp;
            end
            res[1919 - 32*i -: 32] = wd[i];
        end
        return res;
    endfunction

    // Forward cipher on a 16-byte array, byte k = state[k%4][k/4].
    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1919:0] wa, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ wa[1919 - 8*i -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*col] = t[row + 4*((col + row) % 4)];
            if (rd != nr) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*col+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ wa[1919 - 128*rd - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- scoreboard for the Nr=10 instance ----------------
    always @(posedge clk) begin
        logic [127:0] e;
        #1;
        if (done_v[0]) begin
            if (exp_q.size() == 0) begin
                check("u10_spurious_done", {127'b0, done_v[0]}, 128'b0);
            end else begin
                e = exp_q.pop_front();
                check("u10_out", out_v[0], e);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_block(input int k, input logic [127:0] ct, input logic [127:0] exp,
                             input int lat, input string tag);
        int cyc;
        if (k == 0) exp_q.push_back(exp);
        @(negedge clk);
        start_v[k] = 1'b1;
        in_v[k]    = ct;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        in_v[k]    = {$urandom(), $urandom(), $urandom(), $urandom()};
        check({tag, "_busy"}, 128'(busy_v[k]), 128'd1);
        cyc = 0;
        while (!done_v[k] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc), 128'(lat));
        check({tag, "_busy_at_done"}, 128'(busy_v[k]), 128'd0);
        if (k != 0) check({tag, "_out"}, out_v[k], exp);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 128'(done_v[k]), 128'd0);
        check({tag, "_hold"}, out_v[k], exp);
    endtask

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [1919:0] wall;
        logic [127:0]  pt;
        logic [127:0]  ct;
        logic [127:0]  key;
        int            nd;
        int            d1;
        int            d2;

        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start_v = 3'b000;
        for (int k = 0; k < 3; k++) in_v[k] = '0;
        build_sbox();
        wall = expand({KEY_B, 128'h0}, 4);
        w10  = wall[1919 -: 1408];
        wall = expand({KEY_C2, 64'h0}, 6);
        w12  = wall[1919 -: 1664];
        w14  = expand(KEY_C3, 8);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy_v), 128'd0);
        check("rst_done", 128'(done_v), 128'd0);
        check("rst_out10", out_v[0], 128'd0);
        check("rst_out12", out_v[1], 128'd0);
        check("rst_out14", out_v[2], 128'd0);
        check("rst_fsm", 128'(dbg_v[0]), 128'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Known answer vectors
        run_block(0, CT_B, PT_B, 10, "appb");
        wall = expand({KEY_C1, 128'h0}, 4);
        w10  = wall[1919 -: 1408];
        run_block(0, CT_C1, PT_C, 10, "c1");
        run_block(1, CT_C2, PT_C, 12, "c2");
        run_block(2, CT_C3, PT_C, 14, "c3");

        // Round trip of the forward cipher's output
        ct = enc(PT_B, wall, 10);
        run_block(0, ct, PT_B, 10, "roundtrip");

        // Random keys and blocks
        for (int n = 0; n < 6; n++) begin
            key  = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt   = {$urandom(), $urandom(), $urandom(), $urandom()};
            wall = expand({key, 128'h0}, 4);
            w10  = wall[1919 -: 1408];
            ct   = enc(pt, wall, 10);
            run_block(0, ct, pt, 10, "rand");
        end

        // start during a run is ignored
        wall = expand({KEY_C1, 128'h0}, 4);
        w10  = wall[1919 -: 1408];
        exp_q.push_back(PT_C);
        @(negedge clk);
        start_v[0] = 1'b1;
        in_v[0]    = CT_C1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        nd = 0;
        d1 = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 4) begin
                start_v[0] = 1'b1;
                in_v[0]    = CT_B;
            end
            if (cyc == 5) start_v[0] = 1'b0;
            if (done_v[0]) begin
                nd++;
                if (d1 < 0) d1 = cyc;
            end
        end
        check("ignore_done_count", 128'(nd), 128'd1);
        check("ignore_latency", 128'(d1), 128'd10);

        // Reset in the middle of a block
        wall = expand({KEY_B, 128'h0}, 4);
        w10  = wall[1919 -: 1408];
        @(negedge clk);
        start_v[0] = 1'b1;
        in_v[0]    = CT_B;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 128'(busy_v[0]), 128'd0);
        check("abort_done", 128'(done_v[0]), 128'd0);
        check("abort_out", out_v[0], 128'd0);
        check("abort_fsm", 128'(dbg_v[0]), 128'(S_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (done_v[0]) nd++;
        end
        check("abort_no_done", 128'(nd), 128'd0);
        run_block(0, CT_B, PT_B, 10, "after_rst");

        // Back-to-back with start held high
        wall = expand({KEY_C1, 128'h0}, 4);
        w10  = wall[1919 -: 1408];
        ct   = enc(PT_B, wall, 10);
        exp_q.push_back(PT_C);
        exp_q.push_back(PT_B);
        @(negedge clk);
        start_v[0] = 1'b1;
        in_v[0]    = CT_C1;
        @(posedge clk); #1;
        in_v[0] = ct;
        nd = 0;
        d1 = -1;
        d2 = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 10) start_v[0] = 1'b0;
            if (done_v[0]) begin
                nd++;
                if (nd == 1) d1 = cyc;
                else if (nd == 2) d2 = cyc;
            end
        end
        check("b2b_done_count", 128'(nd), 128'd2);
        check("b2b_first", 128'(d1), 128'd10);
        check("b2b_second", 128'(d2), 128'd20);

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/inv_cipher_iter.md
# inv_cipher_iter

Iterative AES inverse cipher (FIPS-197 §5.3) that decrypts one 128-bit block using the round-key schedule produced by the existing key-expansion block. It is the decryption counterpart of the combinational cipher. It sits on the receive side of the SPI datapath and takes a ciphertext block and the expanded key, then returns plaintext. One inverse round is evaluated per clock, which trades latency for area versus a fully unrolled inverse cipher.

## Interface
- Nr, 10: number of rounds (10/12/14 for AES-128/192/256).
- Nk, 4: key length in 32-bit words (4/6/8); must match Nr.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  request to decrypt `in_block`; sampled only while idle.
- in_block  input  128  ciphertext; byte 0 (state[0][0]) in bits [127:120], column-major.
- w  input  128*(Nr+1)  expanded key. Round key r occupies bits [128*(Nr+1)-1-128*r -: 128], so round 0 is at the MSBs.
- busy  output  1  high while a block is in flight.
- done  output  1  one-cycle pulse; `out_block` is valid from this cycle on.
- out_block  output  128  plaintext, same byte order as `in_block`; held until the next `done`.

## Operation
- FSM states: IDLE and RUN. A 4-bit round counter `rnd` and a 128-bit `state` register.
- IDLE with start=1 (edge E0):
  - state <= in_block ^ key(Nr)
  - rnd <= Nr-1
  - busy <= 1
  - go to RUN
- RUN with rnd ≥ 1 (middle round, in this order):
  - InvShiftRows
  - InvSubBytes
  - AddRoundKey(key(rnd))
  - InvMixColumns
  - then rnd <= rnd-1
- RUN with rnd = 0 (final round):
  - InvShiftRows, InvSubBytes, AddRoundKey(key(0)); no InvMixColumns.
  - out_block <= result
  - done <= 1, busy <= 0
  - go to IDLE
- Start handling:
  - `start` while busy is ignored; it is neither queued nor allowed to corrupt the in-flight block.
  - `start` in the same cycle as `done` is accepted, which gives back-to-back operation.
- `in_block` is captured at E0 and may change afterwards. `w` must stay stable from E0 until `done`; this is the caller's responsibility and is not checked.
- GF(2^8) arithmetic uses reduction polynomial 0x11B. InvMixColumns coefficients are 0e/0b/0d/09.

## Timing
- Reset values: busy=0, done=0, out_block=0. Internally: state=0, rnd=0, FSM=IDLE.
- Latency: `start` sampled at E0 → `done` high for exactly one cycle after edge E0+Nr. That is 10 cycles for AES-128, 12 for AES-192, 14 for AES-256.
- busy is high from after E0 through the cycle before `done`, i.e. Nr cycles.
- Throughput is one block per Nr cycles when `start` is held high.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and forces all outputs to their reset values.
  - No `done` pulse is produced for the aborted block.
  - After reset releases, the first `start` begins a fresh block.
- The round counter never wraps: a transition from rnd=0 always leaves RUN.

## Structure
- Shared package `aes_pkg` holds:
  - constants Nb=4 and the block width 128
  - the inverse S-box table as a function
  - the forward S-box, if the package is not already shared with the cipher
  - xtime and GF multiply functions
- One sub-module: `inv_cipher_round`. It is combinational and performs one inverse round, with an input `last` that bypasses InvMixColumns.
- `inv_cipher_iter` holds only the FSM, the counter, the round-key mux and the registers.

## Test plan
- AES-128 (Nr=10), FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 → out_block 3243f6a8885a308d313198a2e0370734. `done` must appear exactly 10 cycles after `start`.
- AES-128, App. C.1: key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → 00112233445566778899aabbccddeeff. Also run a round-trip from the existing cipher's output back to the original block.
- Nr=12, Nk=6: key 000102…17, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191 → 00112233445566778899aabbccddeeff at 12 cycles. Nr=14, Nk=8: key 000102…1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 → same plaintext at 14 cycles.
- Pulse `start` with the C.1 vector, then pulse `start` again at cycle 4 with a different ciphertext. Required: second request ignored, C.1 plaintext unchanged, exactly one `done`.
- Assert rst_n low at cycle 5 of a decryption. Required: busy, done and out_block all 0 immediately and no `done` pulse. After release, the App. B vector decrypts correctly.
- Hold `start` high with the C.1 then App. B ciphertexts. Required: `done` at cycles 10 and 20 with the correct plaintexts in order.
